// File: rtl/ysyx_23060236_wbu_pkg.sv
// Shared definitions for the writeback stage: result-source and load funct3 encodings.
package ysyx_23060236_wbu_pkg;

    // Result source select carried with each retiring instruction.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_CSR  = 2'b11
    } wb_sel_e;

    // Load funct3 encodings (RV32I subset used by RV32E).
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060236_wbu_if.sv
// Retiring-instruction bundle from EXU/LSU into the writeback stage.
//   master : EXU/LSU side, drives in_* and samples in_ready
//   slave  : WBU side, samples in_* and drives in_ready
interface ysyx_23060236_wbu_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_wen;
    logic [1:0]            in_sel;
    logic [DATA_WIDTH-1:0] in_alu;
    logic [DATA_WIDTH-1:0] in_csr;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_dnpc;
    logic [DATA_WIDTH-1:0] in_ldata;
    logic [2:0]            in_lfunct;
    logic [1:0]            in_laddr_lo;

    modport master (
        output in_valid, in_rd, in_wen, in_sel, in_alu, in_csr, in_pc, in_dnpc,
               in_ldata, in_lfunct, in_laddr_lo,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_wen, in_sel, in_alu, in_csr, in_pc, in_dnpc,
               in_ldata, in_lfunct, in_laddr_lo,
        output in_ready
    );
endinterface

// File: rtl/ysyx_23060236_load_ext.sv
// Combinational load align/extend.
//   ldata    : aligned memory word
//   lfunct   : load funct3
//   laddr_lo : byte offset within the word
//   result   : extracted, sign/zero-extended value
module ysyx_23060236_load_ext
    import ysyx_23060236_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ldata,
    input  logic [2:0]            lfunct,
    input  logic [1:0]            laddr_lo,
    output logic [DATA_WIDTH-1:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ldata[7:0];
        unique case (laddr_lo)
            2'd0: byte_sel = ldata[7:0];
            2'd1: byte_sel = ldata[15:8];
            2'd2: byte_sel = ldata[23:16];
            2'd3: byte_sel = ldata[31:24];
        endcase
    end

    // Halves are selected by bit 1 only; a misaligned bit 0 is not trapped here.
    assign half_sel = laddr_lo[1] ? ldata[31:16] : ldata[15:0];

    always_comb begin
        result = ldata;
        case (lfunct)
            LOAD_LB:  result = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LOAD_LH:  result = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LOAD_LW:  result = ldata;
            LOAD_LBU: result = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LOAD_LHU: result = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default:  result = ldata;
        endcase
    end
endmodule

// File: rtl/ysyx_23060236_wbu.sv
// Writeback stage: one-entry retire register, result select, RF write port, commit
// handshake to IFU and per-register pending-write scoreboard for IDU.
//   clock, reset      : core clock, synchronous active-high reset
//   io (slave)        : retiring instruction from EXU/LSU
//   iss_valid, iss_rd : IDU issuing an rd-writing instruction
//   busy              : pending-write bit per register, bit 0 tied low
//   rf_*              : register-file write port, written on the fire cycle
//   commit_*          : next-PC handshake to IFU
module ysyx_23060236_wbu
    import ysyx_23060236_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_23060236_wbu_if.slave         io,
    input  logic                       iss_valid,
    input  logic [ADDR_WIDTH-1:0]      iss_rd,
    output logic [2**ADDR_WIDTH-1:0]   busy,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic                       rf_wen,
    output logic                       rf_valid,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic [DATA_WIDTH-1:0]      commit_pc
);
    logic                       full_q, full_d;
    logic [2**ADDR_WIDTH-1:0]   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [ADDR_WIDTH-1:0]      waddr_q;
    logic                       wen_q;
    logic [DATA_WIDTH-1:0]      pc_q;
    logic [DATA_WIDTH-1:0]      load_val;
    logic [DATA_WIDTH-1:0]      result;
    logic                       accept;
    logic                       fire;

    ysyx_23060236_load_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_ext (
        .ldata    (io.in_ldata),
        .lfunct   (io.in_lfunct),
        .laddr_lo (io.in_laddr_lo),
        .result   (load_val)
    );

    always_comb begin
        result = io.in_alu;
        unique case (wb_sel_e'(io.in_sel))
            WB_SEL_ALU:  result = io.in_alu;
            WB_SEL_LOAD: result = load_val;
            WB_SEL_PC4:  result = io.in_pc + DATA_WIDTH'(4);
            WB_SEL_CSR:  result = io.in_csr;
        endcase
    end

    // Gating with reset makes a mid-operation reset suppress the RF write in that cycle.
    assign commit_valid = full_q & ~reset;
    assign fire         = commit_valid & commit_ready;
    assign io.in_ready  = ~full_q | commit_ready;
    assign accept       = io.in_valid & io.in_ready;

    always_comb begin
        full_d = full_q;
        if (accept) begin
            full_d = 1'b1;
        end else if (fire) begin
            full_d = 1'b0;
        end
    end

    // Clear first so a same-cycle set on the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (fire && wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q  <= 1'b0;
            busy_q  <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
            pc_q    <= '0;
        end else begin
            full_q <= full_d;
            busy_q <= busy_d;
            if (accept) begin
                wdata_q <= result;
                waddr_q <= io.in_rd;
                wen_q   <= io.in_wen & (io.in_rd != '0);
                pc_q    <= io.in_dnpc;
            end
        end
    end

    assign busy      = busy_q;
    assign rf_wdata  = wdata_q;
    assign rf_waddr  = waddr_q;
    assign rf_wen    = wen_q;
    assign rf_valid  = fire;
    assign commit_pc = pc_q;
endmodule

// File: tb/tb_ysyx_23060236_wbu.sv
// Randomised self-checking bench for the writeback stage against a queue-free
// behavioural model of one retire slot plus a pending-write bitmap.
module tb_ysyx_23060236_wbu;
    logic        clock;
    logic        reset;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic [15:0] busy;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_waddr;
    logic        rf_wen;
    logic        rf_valid;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;

    ysyx_23060236_wbu_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) wbif ();

    ysyx_23060236_wbu #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io           (wbif.slave),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .busy         (busy),
        .rf_wdata     (rf_wdata),
        .rf_waddr     (rf_waddr),
        .rf_wen       (rf_wen),
        .rf_valid     (rf_valid),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_pc    (commit_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic [31:0] wdata;
        logic [3:0]  waddr;
        bit          wen;
        logic [31:0] pc;
    } ent_t;

    bit          m_full = 0;
    ent_t        m_ent;
    bit          m_busy [16];

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = 0;
        for (int i = 0; i < 16; i++) if (m_busy[i]) v = v + (32'd1 << i);
        return v;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f, logic [1:0] lo);
        int unsigned off_b = 8 * int'(lo);
        int unsigned off_h = 16 * (int'(lo) / 2);
        int unsigned b = (w >> off_b) % 256;
        int unsigned h = (w >> off_h) % 65536;
        case (int'(f))
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return b;
            5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_result();
        case (int'(wbif.in_sel))
            0: return wbif.in_alu;
            1: return ref_load(wbif.in_ldata, wbif.in_lfunct, wbif.in_laddr_lo);
            2: return wbif.in_pc + 32'd4;
            default: return wbif.in_csr;
        endcase
    endfunction

    task automatic rand_in();
        wbif.in_valid    = ($urandom_range(0, 9) < 6);
        wbif.in_rd       = 4'($urandom);
        wbif.in_wen      = ($urandom_range(0, 3) != 0);
        wbif.in_sel      = 2'($urandom);
        wbif.in_alu      = $urandom;
        wbif.in_csr      = $urandom;
        wbif.in_pc       = $urandom;
        wbif.in_dnpc     = $urandom;
        wbif.in_ldata    = $urandom;
        wbif.in_lfunct   = 3'($urandom);
        wbif.in_laddr_lo = 2'($urandom);
        iss_valid        = ($urandom_range(0, 9) < 4);
        iss_rd           = 4'($urandom);
        commit_ready     = ($urandom_range(0, 9) < 6);
    endtask

    task automatic set_in(input bit v, input logic [3:0] rd, input bit wen, input logic [1:0] sel,
                          input logic [31:0] ldata, input logic [2:0] f, input logic [1:0] lo);
        wbif.in_valid    = v;
        wbif.in_rd       = rd;
        wbif.in_wen      = wen;
        wbif.in_sel      = sel;
        wbif.in_ldata    = ldata;
        wbif.in_lfunct   = f;
        wbif.in_laddr_lo = lo;
        iss_valid        = 1'b0;
    endtask

    // Checks DUT against the model mid-cycle, then advances the model across the posedge.
    task automatic step();
        bit exp_ready, fire, acc;
        @(negedge clock);
        exp_ready = !m_full || commit_ready;
        if (reset) begin
            check("rst_rf_valid", rf_valid, 0);
            check("rst_commit_valid", commit_valid, 0);
            m_full = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            check("in_ready", wbif.in_ready, exp_ready);
            check("commit_valid", commit_valid, m_full);
            check("rf_valid", rf_valid, m_full && commit_ready);
            check("busy", busy, busy_vec());
            if (m_full) begin
                check("rf_wdata", rf_wdata, m_ent.wdata);
                check("rf_waddr", rf_waddr, m_ent.waddr);
                check("rf_wen", rf_wen, m_ent.wen);
                check("commit_pc", commit_pc, m_ent.pc);
            end
            fire = m_full && commit_ready;
            acc  = wbif.in_valid && exp_ready;
            if (fire && m_ent.wen) m_busy[m_ent.waddr] = 0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
            if (acc) begin
                m_ent.wdata = ref_result();
                m_ent.waddr = wbif.in_rd;
                m_ent.wen   = wbif.in_wen && (wbif.in_rd != 0);
                m_ent.pc    = wbif.in_dnpc;
                m_full      = 1;
            end else if (fire) begin
                m_full = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        rand_in();
        reset = 1'b1;
        @(posedge clock);
        #1;
        step();
        step();
        reset = 1'b0;
        wbif.in_valid = 1'b0;
        iss_valid     = 1'b0;
        #1;
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_rf_waddr", rf_waddr, 0);
        check("reset_rf_wen", rf_wen, 0);
        check("reset_commit_pc", commit_pc, 0);
        check("reset_busy", busy, 0);
        step();

        // lb from byte 3 sign-extends 0x80.
        set_in(1, 4'd5, 1, 2'b01, 32'h80FF_7F01, 3'b000, 2'd3);
        commit_ready = 1'b0;
        step();
        check("t1_commit_valid", commit_valid, 1);
        check("t1_wdata", rf_wdata, 32'hFFFF_FF80);
        check("t1_waddr", rf_waddr, 5);
        check("t1_wen", rf_wen, 1);

        // lhu / lh / lw on the same word, back-to-back.
        commit_ready = 1'b1;
        set_in(1, 4'd3, 1, 2'b01, 32'h8001_1234, 3'b101, 2'd2);
        step();
        check("t2_lhu", rf_wdata, 32'h0000_8001);
        set_in(1, 4'd3, 1, 2'b01, 32'h8001_1234, 3'b001, 2'd2);
        step();
        check("t2_lh", rf_wdata, 32'hFFFF_8001);
        set_in(1, 4'd3, 1, 2'b01, 32'h8001_1234, 3'b010, 2'd2);
        step();
        check("t2_lw", rf_wdata, 32'h8001_1234);

        // Stall for three cycles then release.
        set_in(0, 4'd2, 1, 2'b00, 0, 0, 0);
        step();
        set_in(1, 4'd9, 1, 2'b00, 0, 0, 0);
        step();
        commit_ready = 1'b0;
        wbif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        wbif.in_valid = 1'b0;
        commit_ready  = 1'b1;
        step();
        step();

        // Back-to-back commits.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 4'($urandom), 1, 2'b10, 0, 0, 0);
            wbif.in_pc   = $urandom;
            wbif.in_dnpc = $urandom;
            step();
        end
        wbif.in_valid = 1'b0;
        step();

        // Scoreboard set-wins over same-index clear, then a lone clear.
        commit_ready = 1'b0;
        set_in(0, 4'd7, 1, 2'b00, 0, 0, 0);
        iss_valid = 1'b1; iss_rd = 4'd7;
        step();
        set_in(1, 4'd7, 1, 2'b00, 0, 0, 0);
        step();
        commit_ready = 1'b1;
        set_in(0, 4'd7, 1, 2'b00, 0, 0, 0);
        iss_valid = 1'b1; iss_rd = 4'd7;
        step();
        check("t5_busy7_set_wins", 32'(busy[7]), 1);
        set_in(1, 4'd7, 1, 2'b00, 0, 0, 0);
        step();
        set_in(0, 4'd7, 1, 2'b00, 0, 0, 0);
        step();
        check("t5_busy7_cleared", 32'(busy[7]), 0);

        // x0 destination never writes.
        set_in(1, 4'd0, 1, 2'b10, 0, 0, 0);
        wbif.in_pc = 32'hFFFF_FFFC;
        commit_ready = 1'b0;
        step();
        check("t6_rf_wen_x0", rf_wen, 0);
        check("t6_busy0", 32'(busy[0]), 0);
        check("t6_pc4_wrap", rf_wdata, 32'h0);

        // Reset during a stall with a pending register.
        set_in(0, 4'd4, 1, 2'b00, 0, 0, 0);
        iss_valid = 1'b1; iss_rd = 4'd11;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        iss_valid = 1'b0;
        check("t6_reset_commit_valid", commit_valid, 0);
        check("t6_reset_busy", busy, 0);
        step();

        for (int i = 0; i < 400; i++) begin
            rand_in();
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
